// File: rtl/midi_rx_pkg.sv
// rtl/midi_rx_pkg.sv - shared types and helpers for the MIDI UART receiver
package midi_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [7:0] MIDI_CLOCK     = 8'hF8;
    localparam logic [7:0] MIDI_ACT_SENSE = 8'hFE;

    // Bits needed to hold 0..n-1; never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// rtl/midi_byte_fifo.sv - first-word-fall-through byte FIFO with push/pop, level and overrun pulse
module midi_byte_fifo
    import midi_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic                     rd_ready_o,
    output logic [7:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overrun_o
);
    localparam int AW = cnt_width(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          empty, full, do_pop, do_push;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_LVL);
        do_pop    = pop_i && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push   = push_i && (!full || do_pop);
        overrun_d = push_i && full && !do_pop;
        wr_d      = do_push ? wr_q + 1'b1 : wr_q;
        rd_d      = do_pop ? rd_q + 1'b1 : rd_q;
        count_d   = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign rd_ready_o = !empty;
    assign rd_data_o  = empty ? 8'h00 : mem_q[rd_q];
    assign level_o    = count_q;
    assign overrun_o  = overrun_q;

endmodule

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI 8N1 receiver feeding a FWFT byte FIFO; define MIDI_RT_FILTER_EN to drop F8/FE bytes
module midi_uart_rx
    import midi_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          data_clk,
    input  logic                          reset_n,
    input  logic                          midi_rxd,
    output logic                          byte_ready,
    output logic [7:0]                    byte_out,
    input  logic                          byte_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          framing_err,
    output logic                          overrun
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int BW   = cnt_width(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          ferr_q, ferr_d;
    logic          keep;

    assign rx_s = sync_q[1];

`ifdef MIDI_RT_FILTER_EN
    assign keep = (shift_q != MIDI_CLOCK) && (shift_q != MIDI_ACT_SENSE);
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge data_clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], midi_rxd};
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        push_d  = keep;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            BREAK: begin
                // Held-low line: stay here so a long break reports only once.
                baud_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    midi_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (data_clk),
        .reset_n_i   (reset_n),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (byte_ack),
        .rd_ready_o  (byte_ready),
        .rd_data_o   (byte_out),
        .level_o     (fifo_level),
        .overrun_o   (overrun)
    );

    assign framing_err = ferr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - self-checking bench for midi_uart_rx (queue reference model)
module tb_midi_uart_rx;
    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DEPTH  = 8;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     midi_rxd = 1'b1;
    logic                     byte_ack = 1'b0;
    logic                     byte_ready;
    logic [7:0]               byte_out;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     framing_err;
    logic                     overrun;

    int errors = 0, checks = 0;
    int ferr_cnt = 0, ovr_cnt = 0, exp_ferr = 0, exp_ovr = 0;
    int lat = -1;
    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0] data;
        int         exp_level;
        int         exp_head;
        int         exp_ovr_d;
    } vec_t;
    vec_t vecs[9];

    midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .data_clk    (clk),
        .reset_n     (reset_n),
        .midi_rxd    (midi_rxd),
        .byte_ready  (byte_ready),
        .byte_out    (byte_out),
        .byte_ack    (byte_ack),
        .fifo_level  (fifo_level),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
    end

    function automatic bit is_rt(input logic [7:0] b);
`ifdef MIDI_RT_FILTER_EN
        return (b == 8'hF8) || (b == 8'hFE);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a received frame either reports a framing error, is filtered,
    // joins the queue, or is lost to overrun when the queue already holds DEPTH.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_ferr++;
        else if (!is_rt(b)) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovr++;
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_level"}, int'(fifo_level), n);
        check({tag, "_ready"}, int'(byte_ready), (n > 0) ? 1 : 0);
        check({tag, "_head"}, int'(byte_out), (n > 0) ? int'(model_q[0]) : 0);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    endtask

    // Drives one 10-bit frame, one line bit per DIV cycles, starting at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                              input int rst_at, output int rdy_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        rdy_at = -1;
        for (int i = 0; i < 10 * DIV; i++) begin
            if (rdy_at < 0 && byte_ready) rdy_at = i;
            if (rst_at >= 0 && i >= rst_at) begin
                midi_rxd = 1'b1;
                reset_n  = (i >= rst_at + 2);
            end else begin
                midi_rxd = fr[i / DIV];
            end
            byte_ack = (i == ack_at);
            @(negedge clk);
        end
        midi_rxd = 1'b1;
        byte_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        midi_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input int exp_b);
        check({tag, "_ready"}, int'(byte_ready), 1);
        check({tag, "_byte"}, int'(byte_out), exp_b);
        byte_ack = 1'b1;
        @(negedge clk);
        byte_ack = 1'b0;
        if (model_q.size() > 0) model_q.delete(0);
    endtask

    initial begin
        int r, o0, n;
        logic [7:0] b;
        logic st;
        logic [7:0] rt_seq[4];

        vecs[0] = '{8'h01, 1, 1, 0};
        vecs[1] = '{8'h02, 2, 1, 0};
        vecs[2] = '{8'h03, 3, 1, 0};
        vecs[3] = '{8'h04, 4, 1, 0};
        vecs[4] = '{8'h05, 5, 1, 0};
        vecs[5] = '{8'h06, 6, 1, 0};
        vecs[6] = '{8'h07, 7, 1, 0};
        vecs[7] = '{8'h08, 8, 1, 0};
        vecs[8] = '{8'h09, 8, 1, 1};
        rt_seq = '{8'hF8, 8'h90, 8'hFE, 8'h40};

        repeat (4) @(negedge clk);
        check("rst_ready", int'(byte_ready), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_byte", int'(byte_out), 0);
        check("rst_ferr", int'(framing_err), 0);
        check("rst_ovr", int'(overrun), 0);
        reset_n = 1'b1;
        idle(DIV);

        // Single byte, latency and ack
        send_frame(8'h90, 1'b1, -1, -1, r);
        model_frame(8'h90, 1'b1);
        lat = r;
        checks++;
        if (lat < 9 * DIV + HALF || lat > 9 * DIV + HALF + 6) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, 9 * DIV + HALF, 9 * DIV + HALF + 6);
            lat = 9 * DIV + HALF + 4;
        end
        idle(2);
        check_state("single");
        pop_check("single_pop", 8'h90);
        check_state("single_after_ack");

        // Reset during bit 4 of 0x90, then 0x3C
        send_frame(8'h90, 1'b1, -1, 5 * DIV + 4, r);
        model_q.delete();
        check_state("midrst");
        send_frame(8'h3C, 1'b1, -1, -1, r);
        model_frame(8'h3C, 1'b1);
        idle(2);
        check_state("midrst_next");
        pop_check("midrst_pop", 8'h3C);

        // Short glitch is rejected silently
        midi_rxd = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        idle(10 * DIV);
        check_state("glitch");

        // Framing error followed by a held-low break
        send_frame(8'h45, 1'b0, -1, -1, r);
        midi_rxd = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        idle(2 * DIV);
        model_frame(8'h45, 1'b0);
        check_state("framing");
        send_frame(8'h7F, 1'b1, -1, -1, r);
        model_frame(8'h7F, 1'b1);
        idle(2);
        check_state("framing_next");
        pop_check("framing_pop", 8'h7F);

        // Overrun table
        for (int k = 0; k < 9; k++) begin
            o0 = ovr_cnt;
            send_frame(vecs[k].data, 1'b1, -1, -1, r);
            model_frame(vecs[k].data, 1'b1);
            idle(2);
            check($sformatf("vec%0d_level", k), int'(fifo_level), vecs[k].exp_level);
            check($sformatf("vec%0d_head", k), int'(byte_out), vecs[k].exp_head);
            check($sformatf("vec%0d_ovr", k), ovr_cnt - o0, vecs[k].exp_ovr_d);
        end
        for (int k = 0; k < 8; k++) pop_check($sformatf("drain%0d", k), k + 1);
        check_state("drained");

        // Ack lands in the same cycle as the push into a full FIFO
        for (int k = 0; k < 8; k++) begin
            send_frame(8'h11 + 8'(k), 1'b1, -1, -1, r);
            model_frame(8'h11 + 8'(k), 1'b1);
        end
        idle(2);
        o0 = ovr_cnt;
        send_frame(8'h19, 1'b1, lat - 1, -1, r);
        model_q.delete(0);
        model_frame(8'h19, 1'b1);
        idle(2);
        check("samecycle_level", int'(fifo_level), 8);
        check("samecycle_ovr", ovr_cnt - o0, 0);
        check("samecycle_head", int'(byte_out), 8'h12);
        for (int k = 0; k < 8; k++) pop_check($sformatf("sc_drain%0d", k), 8'h12 + k);

        // Real-time message filtering
        for (int k = 0; k < 4; k++) begin
            send_frame(rt_seq[k], 1'b1, -1, -1, r);
            model_frame(rt_seq[k], 1'b1);
        end
        idle(2);
        check_state("rtfilt");
        while (model_q.size() > 0) pop_check("rtfilt_pop", int'(model_q[0]));

        // Randomized frames with random acks between them
        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b = ($urandom_range(0, 1) == 0) ? 8'hF8 : 8'hFE;
            st = ($urandom_range(0, 5) != 0);
            send_frame(b, st, -1, -1, r);
            model_frame(b, st);
            idle(DIV);
            check_state($sformatf("rand%0d", k));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n && model_q.size() > 0; j++)
                pop_check($sformatf("rand%0d_pop", k), int'(model_q[0]));
        end
        idle(2);
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
